// File: rtl/gb_cpu_regfile_pipe.sv
// rtl/gb_cpu_regfile_pipe.sv - SM83 register file with prioritised write merge and writeback pipeline
// Optional feature macro: GB_CPU_REGFILE_FWD_EN (rd_data overlays pending pipeline writes)
module gb_cpu_regfile_pipe #(
  parameter int NUM_R8_WR = 3,
  parameter int NUM_RD    = 2,
  parameter int WB_STAGES = 1,
  parameter int POST_BOOT = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   hold,
  input  logic [NUM_R8_WR-1:0]   r8_wr_en,
  input  logic [3*NUM_R8_WR-1:0] r8_wr_sel,
  input  logic [8*NUM_R8_WR-1:0] r8_wr_data,
  input  logic                   r16_wr_en,
  input  logic [2:0]             r16_wr_sel,
  input  logic [15:0]            r16_wr_data,
  input  logic                   flags_wr_en,
  input  logic [3:0]             flags_wr_mask,
  input  logic [3:0]             flags_wr_data,
  input  logic [3*NUM_RD-1:0]    rd_sel,
  output logic [16*NUM_RD-1:0]   rd_data,
  output logic [15:0]            sp,
  output logic [15:0]            pc,
  output logic [3:0]             flags,
  output logic                   wb_busy,
  output logic                   wr_conflict
);

  // Byte slots: 0 B, 1 C, 2 D, 3 E, 4 H, 5 L, 6 A, 7 F, 8 SPh, 9 SPl, 10 PCh, 11 PCl.
  // Every packet carries a per-bit enable so masked flag updates merge like byte writes.
  localparam int NB = 12;
  localparam int NW = 8 * NB;
  localparam int NS = (WB_STAGES == 0) ? 1 : WB_STAGES;
  localparam logic [3:0] SLOT_F = 4'd7;

  localparam logic [NW-1:0] BOOT_VAL = (POST_BOOT != 0) ?
    {8'h00, 8'h01, 8'hFE, 8'hFF, 8'hB0, 8'h01, 8'h4D, 8'h01, 8'hD8, 8'h00, 8'h13, 8'h00} :
    {NW{1'b0}};

  // r8 selector encoding swaps A/F relative to the slot order
  function automatic logic [3:0] r8_slot(input logic [2:0] sel);
    case (sel)
      3'd6:    return 4'd7;
      3'd7:    return 4'd6;
      default: return {1'b0, sel};
    endcase
  endfunction

  // Slot of the high byte of a pair; the low byte sits in the next slot
  function automatic logic [3:0] pair_hi(input logic [2:0] sel);
    case (sel)
      3'd0:    return 4'd0;
      3'd1:    return 4'd2;
      3'd2:    return 4'd4;
      3'd3:    return 4'd8;
      3'd4:    return 4'd10;
      default: return 4'd6;
    endcase
  endfunction

  function automatic logic [NW-1:0] apply_pkt(input logic [NW-1:0] base,
                                              input logic [NW-1:0] data,
                                              input logic [NW-1:0] en);
    return (base & ~en) | (data & en);
  endfunction

  function automatic logic [15:0] read_pair(input logic [NW-1:0] v, input logic [2:0] sel);
    case (sel)
      3'd0:    return {v[7:0],   v[15:8]};
      3'd1:    return {v[23:16], v[31:24]};
      3'd2:    return {v[39:32], v[47:40]};
      3'd3:    return {v[71:64], v[79:72]};
      3'd4:    return {v[87:80], v[95:88]};
      3'd5:    return {v[55:48], v[63:56]};
      default: return 16'h0000;
    endcase
  endfunction

  logic [NW-1:0] arch;
  logic [NW-1:0] view;
  logic [NW-1:0] in_data;
  logic [NW-1:0] in_en;
  logic          in_valid;
  logic          conflict_now;
  logic [NB-1:0] hit;
  logic          cm_valid;
  logic [NW-1:0] cm_data;
  logic [NW-1:0] cm_en;

  // Merge all write sources into one packet, later sources overriding earlier ones
  always_comb begin
    logic [3:0] hi;
    logic [3:0] lo;
    logic [3:0] slot;
    in_data      = '0;
    in_en        = '0;
    hit          = '0;
    conflict_now = 1'b0;
    hi           = pair_hi(r16_wr_sel);
    lo           = hi + 4'd1;
    slot         = 4'd0;
    if (r16_wr_en && (r16_wr_sel <= 3'd5)) begin
      in_data[{hi, 3'b000} +: 16] = {r16_wr_data[7:0], r16_wr_data[15:8]};
      in_en[{hi, 3'b000} +: 16]   = 16'hFFFF;
      hit[hi]                     = 1'b1;
      hit[lo]                     = 1'b1;
    end
    for (int p = 0; p < NUM_R8_WR; p++) begin
      if (r8_wr_en[p]) begin
        slot = r8_slot(r8_wr_sel[3*p +: 3]);
        if (hit[slot]) conflict_now = 1'b1;
        hit[slot]                     = 1'b1;
        in_data[{slot, 3'b000} +: 8] = r8_wr_data[8*p +: 8];
        in_en[{slot, 3'b000} +: 8]   = 8'hFF;
      end
    end
    if (flags_wr_en && (flags_wr_mask != 4'h0)) begin
      if (hit[SLOT_F]) conflict_now = 1'b1;
      if (flags_wr_mask[3]) begin in_data[63] = flags_wr_data[3]; in_en[63] = 1'b1; end
      if (flags_wr_mask[2]) begin in_data[62] = flags_wr_data[2]; in_en[62] = 1'b1; end
      if (flags_wr_mask[1]) begin in_data[61] = flags_wr_data[1]; in_en[61] = 1'b1; end
      if (flags_wr_mask[0]) begin in_data[60] = flags_wr_data[0]; in_en[60] = 1'b1; end
    end
    // F low nibble is hardwired to zero whatever the source wrote
    in_data[59:56] = 4'h0;
  end

  assign in_valid = !hold && (|in_en);

  generate
    if (WB_STAGES == 0) begin : g_direct
      assign cm_valid = in_valid;
      assign cm_data  = in_data;
      assign cm_en    = in_en;
      assign wb_busy  = 1'b0;
      assign view     = arch;
    end else begin : g_pipe
      logic [NS-1:0]         st_valid;
      logic [NS-1:0][NW-1:0] st_data;
      logic [NS-1:0][NW-1:0] st_en;

      // Shift packets toward commit; stage 0 is the youngest
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          st_valid <= '0;
          st_data  <= '0;
          st_en    <= '0;
        end else if (!hold) begin
          st_valid[0] <= in_valid;
          st_data[0]  <= in_data;
          st_en[0]    <= in_en;
          for (int i = 1; i < NS; i++) begin
            st_valid[i] <= st_valid[i-1];
            st_data[i]  <= st_data[i-1];
            st_en[i]    <= st_en[i-1];
          end
        end
      end

      assign cm_valid = st_valid[NS-1];
      assign cm_data  = st_data[NS-1];
      assign cm_en    = st_en[NS-1];
      assign wb_busy  = |st_valid;

`ifdef GB_CPU_REGFILE_FWD_EN
      // Overlay pending packets oldest-first so the youngest one wins each bit
      always_comb begin
        view = arch;
        for (int i = NS - 1; i >= 0; i--) begin
          if (st_valid[i]) view = apply_pkt(view, st_data[i], st_en[i]);
        end
      end
`else
      assign view = arch;
`endif
    end
  endgenerate

  // Architectural state: commit the oldest packet unless frozen
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      arch <= BOOT_VAL;
    end else if (!hold && cm_valid) begin
      arch <= apply_pkt(arch, cm_data, cm_en);
    end
  end

  // Collision flag is a one-cycle registered echo of the merge result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_conflict <= 1'b0;
    end else if (hold) begin
      wr_conflict <= 1'b0;
    end else begin
      wr_conflict <= conflict_now;
    end
  end

  genvar gp;
  generate
    for (gp = 0; gp < NUM_RD; gp++) begin : g_rd
      assign rd_data[16*gp +: 16] = read_pair(view, rd_sel[3*gp +: 3]);
    end
  endgenerate

  assign sp    = {arch[71:64], arch[79:72]};
  assign pc    = {arch[87:80], arch[95:88]};
  assign flags = arch[63:60];

endmodule

// File: tb/tb_gb_cpu_regfile_pipe.sv
// tb/tb_gb_cpu_regfile_pipe.sv - scoreboard bench for gb_cpu_regfile_pipe
module tb_gb_cpu_regfile_pipe;

  logic        clk;
  logic        reset;
  logic        hold;
  logic [2:0]  r8_wr_en;
  logic [8:0]  r8_wr_sel;
  logic [23:0] r8_wr_data;
  logic        r16_wr_en;
  logic [2:0]  r16_wr_sel;
  logic [15:0] r16_wr_data;
  logic        flags_wr_en;
  logic [3:0]  flags_wr_mask;
  logic [3:0]  flags_wr_data;
  logic [5:0]  rd_sel;
  logic [31:0] rd_data;
  logic [15:0] sp;
  logic [15:0] pc;
  logic [3:0]  flags;
  logic        wb_busy;
  logic        wr_conflict;

`ifdef GB_CPU_REGFILE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct {
    logic [2:0]  sel;
    logic [15:0] val;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] sp_q[$];
  int          n_pass;
  int          n_total;

  gb_cpu_regfile_pipe #(
    .NUM_R8_WR(3),
    .NUM_RD(2),
    .WB_STAGES(1),
    .POST_BOOT(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .hold(hold),
    .r8_wr_en(r8_wr_en),
    .r8_wr_sel(r8_wr_sel),
    .r8_wr_data(r8_wr_data),
    .r16_wr_en(r16_wr_en),
    .r16_wr_sel(r16_wr_sel),
    .r16_wr_data(r16_wr_data),
    .flags_wr_en(flags_wr_en),
    .flags_wr_mask(flags_wr_mask),
    .flags_wr_data(flags_wr_data),
    .rd_sel(rd_sel),
    .rd_data(rd_data),
    .sp(sp),
    .pc(pc),
    .flags(flags),
    .wb_busy(wb_busy),
    .wr_conflict(wr_conflict)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic clear_inputs();
    hold          = 1'b0;
    r8_wr_en      = '0;
    r8_wr_sel     = '0;
    r8_wr_data    = '0;
    r16_wr_en     = 1'b0;
    r16_wr_sel    = '0;
    r16_wr_data   = '0;
    flags_wr_en   = 1'b0;
    flags_wr_mask = '0;
    flags_wr_data = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic r8_write(input int port, input logic [2:0] sel, input logic [7:0] data);
    r8_wr_en[port]          = 1'b1;
    r8_wr_sel[3*port +: 3]  = sel;
    r8_wr_data[8*port +: 8] = data;
  endtask

  task automatic r16_write(input logic [2:0] sel, input logic [15:0] data);
    r16_wr_en   = 1'b1;
    r16_wr_sel  = sel;
    r16_wr_data = data;
  endtask

  task automatic read_pair(input logic [2:0] sel, output logic [15:0] v);
    rd_sel[2:0] = sel;
    #1;
    v = rd_data[15:0];
  endtask

  task automatic sb_push(input logic [2:0] sel, input logic [15:0] val);
    exp_t e;
    e.sel = sel;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic test_reset();
    logic [15:0] v;
    clear_inputs();
    reset  = 1'b0;
    rd_sel = {3'd7, 3'd5};
    #2 reset = 1'b1;
    #1;
    read_pair(3'd5, v);
    n_total++; if (v !== 16'h01B0) $display("FAIL reset_af got=%h want=%h", v, 16'h01B0); else n_pass++;
    read_pair(3'd0, v);
    n_total++; if (v !== 16'h0013) $display("FAIL reset_bc got=%h want=%h", v, 16'h0013); else n_pass++;
    read_pair(3'd1, v);
    n_total++; if (v !== 16'h00D8) $display("FAIL reset_de got=%h want=%h", v, 16'h00D8); else n_pass++;
    read_pair(3'd2, v);
    n_total++; if (v !== 16'h014D) $display("FAIL reset_hl got=%h want=%h", v, 16'h014D); else n_pass++;
    n_total++; if (sp !== 16'hFFFE) $display("FAIL reset_sp got=%h want=%h", sp, 16'hFFFE); else n_pass++;
    n_total++; if (pc !== 16'h0100) $display("FAIL reset_pc got=%h want=%h", pc, 16'h0100); else n_pass++;
    n_total++; if (flags !== 4'hB) $display("FAIL reset_flags got=%h want=%h", flags, 4'hB); else n_pass++;
    n_total++; if (wb_busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", wb_busy); else n_pass++;
    n_total++; if (wr_conflict !== 1'b0) $display("FAIL reset_conflict got=%b want=0", wr_conflict); else n_pass++;
    n_total++; if (rd_data[31:16] !== 16'h0000) $display("FAIL rd_sel7_zero got=%h want=0000", rd_data[31:16]); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    rd_sel[5:3] = 3'd6;
    tick();
  endtask

  task automatic test_r8_pipeline();
    logic [15:0] v;
    exp_t e;
    r8_write(0, 3'd7, 8'h5A);
    sb_push(3'd5, 16'h5AB0);
    tick();
    clear_inputs();
    n_total++; if (wb_busy !== 1'b1) $display("FAIL r8_busy got=%b want=1", wb_busy); else n_pass++;
    read_pair(3'd5, v);
    n_total++;
    if (v !== (FWD ? 16'h5AB0 : 16'h01B0))
      $display("FAIL r8_pending_read got=%h want=%h", v, (FWD ? 16'h5AB0 : 16'h01B0));
    else n_pass++;
    tick();
    n_total++; if (wb_busy !== 1'b0) $display("FAIL r8_busy_done got=%b want=0", wb_busy); else n_pass++;
    e = sb_q.pop_front();
    read_pair(e.sel, v);
    n_total++; if (v !== e.val) $display("FAIL r8_commit got=%h want=%h", v, e.val); else n_pass++;
  endtask

  task automatic test_conflict();
    logic [15:0] v;
    exp_t e;
    r16_write(3'd2, 16'h1234);
    r8_write(0, 3'd5, 8'hAA);
    r8_write(2, 3'd5, 8'hBB);
    sb_push(3'd2, 16'h12BB);
    tick();
    clear_inputs();
    n_total++; if (wr_conflict !== 1'b1) $display("FAIL conflict_pulse got=%b want=1", wr_conflict); else n_pass++;
    tick();
    n_total++; if (wr_conflict !== 1'b0) $display("FAIL conflict_clear got=%b want=0", wr_conflict); else n_pass++;
    e = sb_q.pop_front();
    read_pair(e.sel, v);
    n_total++; if (v !== e.val) $display("FAIL conflict_hl got=%h want=%h", v, e.val); else n_pass++;
  endtask

  task automatic test_flags();
    logic [15:0] v;
    exp_t e;
    logic [3:0] exp_flags[4];
    logic       exp_conf[4];
    exp_flags = '{4'hB, 4'h5, 4'h3, 4'hB};
    exp_conf  = '{1'b0, 1'b1, 1'b0, 1'b0};
    for (int s = 0; s < 4; s++) begin
      case (s)
        0: begin r16_write(3'd5, 16'h01B0); sb_push(3'd5, 16'h01B0); end
        1: begin
             flags_wr_en = 1'b1; flags_wr_mask = 4'b0101; flags_wr_data = 4'b1111;
             r8_write(1, 3'd6, 8'h00);
             sb_push(3'd5, 16'h0150);
           end
        2: begin r8_write(0, 3'd6, 8'h3F); sb_push(3'd5, 16'h0130); end
        default: begin
             flags_wr_en = 1'b1; flags_wr_mask = 4'b1000; flags_wr_data = 4'b1000;
             sb_push(3'd5, 16'h01B0);
           end
      endcase
      tick();
      clear_inputs();
      n_total++;
      if (wr_conflict !== exp_conf[s]) $display("FAIL flags_conflict_%0d got=%b want=%b", s, wr_conflict, exp_conf[s]);
      else n_pass++;
      tick();
      e = sb_q.pop_front();
      read_pair(e.sel, v);
      n_total++; if (v !== e.val) $display("FAIL flags_af_%0d got=%h want=%h", s, v, e.val); else n_pass++;
      n_total++;
      if (flags !== exp_flags[s]) $display("FAIL flags_out_%0d got=%h want=%h", s, flags, exp_flags[s]);
      else n_pass++;
    end
  endtask

  task automatic test_hold();
    logic [15:0] v;
    exp_t e;
    r16_write(3'd0, 16'hBEEF);
    sb_push(3'd0, 16'hBEEF);
    tick();
    clear_inputs();
    hold = 1'b1;
    r16_write(3'd1, 16'hAAAA);
    r8_write(0, 3'd0, 8'h11);
    r8_write(1, 3'd0, 8'h22);
    for (int i = 0; i < 3; i++) tick();
    read_pair(3'd0, v);
    n_total++;
    if (v !== (FWD ? 16'hBEEF : 16'h0013))
      $display("FAIL hold_bc got=%h want=%h", v, (FWD ? 16'hBEEF : 16'h0013));
    else n_pass++;
    n_total++; if (wb_busy !== 1'b1) $display("FAIL hold_busy got=%b want=1", wb_busy); else n_pass++;
    n_total++; if (wr_conflict !== 1'b0) $display("FAIL hold_conflict got=%b want=0", wr_conflict); else n_pass++;
    clear_inputs();
    tick();
    e = sb_q.pop_front();
    read_pair(e.sel, v);
    n_total++; if (v !== e.val) $display("FAIL hold_release_bc got=%h want=%h", v, e.val); else n_pass++;
    read_pair(3'd1, v);
    n_total++; if (v !== 16'h00D8) $display("FAIL hold_dropped_de got=%h want=%h", v, 16'h00D8); else n_pass++;
    n_total++; if (wb_busy !== 1'b0) $display("FAIL hold_busy_done got=%b want=0", wb_busy); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] vals[4];
    logic [15:0] want;
    vals = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    for (int k = 0; k < 5; k++) begin
      if (k < 4) begin
        r16_write(3'd3, vals[k]);
        sp_q.push_back(vals[k]);
      end else begin
        clear_inputs();
      end
      tick();
      n_total++;
      if (wb_busy !== (k < 4)) $display("FAIL b2b_busy_%0d got=%b want=%b", k, wb_busy, (k < 4));
      else n_pass++;
      if (k >= 1) begin
        n_total++;
        if (sp_q.size() == 0) begin
          $display("FAIL b2b_sp_%0d scoreboard empty", k);
        end else begin
          want = sp_q.pop_front();
          if (sp !== want) $display("FAIL b2b_sp_%0d got=%h want=%h", k, sp, want);
          else n_pass++;
        end
      end
    end
    r16_write(3'd6, 16'hFFFF);
    tick();
    clear_inputs();
    n_total++; if (wb_busy !== 1'b0) $display("FAIL r16_sel6_ignored got=%b want=0", wb_busy); else n_pass++;
    tick();
  endtask

  task automatic test_reset_pending();
    logic [15:0] v;
    r16_write(3'd1, 16'h0102);
    tick();
    clear_inputs();
    n_total++; if (wb_busy !== 1'b1) $display("FAIL rstp_busy_before got=%b want=1", wb_busy); else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_total++; if (wb_busy !== 1'b0) $display("FAIL rstp_busy got=%b want=0", wb_busy); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    tick();
    tick();
    read_pair(3'd1, v);
    n_total++; if (v !== 16'h00D8) $display("FAIL rstp_de got=%h want=%h", v, 16'h00D8); else n_pass++;
    n_total++; if (sp !== 16'hFFFE) $display("FAIL rstp_sp got=%h want=%h", sp, 16'hFFFE); else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_r8_pipeline();
    test_conflict();
    test_flags();
    test_hold();
    test_back_to_back();
    test_reset_pending();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
